// File: rtl/gbe64_rst_sequencer.sv
// Frame-safe reset sequencer for the 64-bit 10GbE TX path: drains the in-flight
// frame, pulses the core reset, waits for link recovery, then re-enables TX.
module gbe64_rst_sequencer #(
  parameter int unsigned RST_CYCLES     = 16,
  parameter int unsigned DRAIN_TIMEOUT  = 1024,
  parameter int unsigned HOLDOFF_CYCLES = 256,
  parameter int unsigned CNT_W          = 16
) (
  input  logic        user_clk,
  input  logic        user_rst,
  input  logic [31:0] sw_reg,
  input  logic        tx_valid_in,
  input  logic        tx_eof_in,
  input  logic        link_up,
  output logic        tx_valid_out,
  output logic        tx_eof_out,
  output logic        gbe_rst,
  output logic        busy,
  output logic [31:0] status
);

  localparam int unsigned RST_W   = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam int unsigned DRAIN_W = (DRAIN_TIMEOUT > 1) ? $clog2(DRAIN_TIMEOUT) : 1;
  localparam int unsigned HOLD_W  = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;

  localparam logic [RST_W-1:0]   RST_LAST   = RST_W'(RST_CYCLES - 1);
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_TIMEOUT - 1);
  localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(HOLDOFF_CYCLES - 1);
  localparam logic [CNT_W-1:0]   COUNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_DRAIN   = 2'd1,
    S_RESET   = 2'd2,
    S_HOLDOFF = 2'd3
  } state_t;

  state_t             state;
  state_t             state_next;
  logic               prev_bit0;
  logic               rst_seen;
  logic               in_frame;
  logic               drain_to;
  logic [RST_W-1:0]   rst_cnt;
  logic [DRAIN_W-1:0] drain_cnt;
  logic [HOLD_W-1:0]  hold_cnt;
  logic [CNT_W-1:0]   rst_count;

  logic req_c;
  logic allow_c;
  logic drain_to_c;
  logic unused_sw;

  assign unused_sw = ^sw_reg[31:2];

  // A bit0 level present when reset releases is masked for one cycle so it is not seen as an edge
  assign req_c = (sw_reg[0] & ~prev_bit0 & ~rst_seen) | sw_reg[1];

  // Next-state and TX gate
  always_comb begin
    state_next = state;
    allow_c    = 1'b0;
    drain_to_c = 1'b0;
    unique case (state)
      S_IDLE: begin
        allow_c = 1'b1;
        if (req_c) state_next = S_DRAIN;
      end
      S_DRAIN: begin
        allow_c = in_frame;
        if (!in_frame || (tx_valid_in && tx_eof_in)) begin
          state_next = S_RESET;
        end else if (drain_cnt == DRAIN_LAST) begin
          state_next = S_RESET;
          drain_to_c = 1'b1;
        end
      end
      S_RESET: begin
        if ((rst_cnt == RST_LAST) && !sw_reg[1]) state_next = S_HOLDOFF;
      end
      S_HOLDOFF: begin
        if (!in_frame && (link_up || (hold_cnt == HOLD_LAST))) state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge user_clk) begin
    if (user_rst) state <= S_IDLE;
    else          state <= state_next;
  end

  // Counters, flags and the registered core reset
  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      prev_bit0 <= 1'b0;
      rst_seen  <= 1'b1;
      in_frame  <= 1'b0;
      drain_to  <= 1'b0;
      gbe_rst   <= 1'b0;
      rst_cnt   <= '0;
      drain_cnt <= '0;
      hold_cnt  <= '0;
      rst_count <= '0;
    end else begin
      prev_bit0 <= sw_reg[0];
      rst_seen  <= 1'b0;
      if (tx_valid_in) in_frame <= ~tx_eof_in;
      gbe_rst <= (state_next == S_RESET);

      if (state != S_DRAIN)          drain_cnt <= '0;
      else if (drain_cnt != DRAIN_LAST) drain_cnt <= drain_cnt + DRAIN_W'(1);

      if (state != S_RESET)          rst_cnt <= '0;
      else if (rst_cnt != RST_LAST)  rst_cnt <= rst_cnt + RST_W'(1);

      if (state != S_HOLDOFF)        hold_cnt <= '0;
      else if (hold_cnt != HOLD_LAST) hold_cnt <= hold_cnt + HOLD_W'(1);

      if (state == S_IDLE && state_next == S_DRAIN) drain_to <= 1'b0;
      else if (drain_to_c)                          drain_to <= 1'b1;

      if (state != S_RESET && state_next == S_RESET && rst_count != COUNT_MAX)
        rst_count <= rst_count + CNT_W'(1);
    end
  end

  assign tx_valid_out = tx_valid_in & allow_c;
  assign tx_eof_out   = tx_eof_in & tx_valid_out;
  assign busy         = (state != S_IDLE);
  assign status       = {16'(rst_count), 13'd0, drain_to, 2'(state)};

endmodule

// File: tb/tb_gbe64_rst_sequencer.sv
// Directed bench for gbe64_rst_sequencer: IDLE pass-through table plus
// hand-built drain, timeout, hold and user_rst sequences.
module tb_gbe64_rst_sequencer;

  logic        user_clk = 1'b0;
  logic        user_rst;
  logic [31:0] sw_reg;
  logic        tx_valid_in;
  logic        tx_eof_in;
  logic        link_up;
  logic        tx_valid_out;
  logic        tx_eof_out;
  logic        gbe_rst;
  logic        busy;
  logic [31:0] status;

  int checks = 0;
  int errors = 0;

  always #5 user_clk = ~user_clk;

  gbe64_rst_sequencer dut (
    .user_clk     (user_clk),
    .user_rst     (user_rst),
    .sw_reg       (sw_reg),
    .tx_valid_in  (tx_valid_in),
    .tx_eof_in    (tx_eof_in),
    .link_up      (link_up),
    .tx_valid_out (tx_valid_out),
    .tx_eof_out   (tx_eof_out),
    .gbe_rst      (gbe_rst),
    .busy         (busy),
    .status       (status)
  );

  typedef struct {
    logic [31:0] sw;
    logic        v;
    logic        e;
    logic        exp_v;
    logic        exp_e;
    logic [31:0] exp_status;
  } vec_t;

  vec_t vecs[$];

  // Inputs change just after the rising edge; outputs are sampled on the falling edge.
  task automatic drive(input logic [31:0] sw, input logic v, input logic e,
                       input logic lk, input logic rst);
    @(posedge user_clk);
    #1;
    sw_reg      = sw;
    tx_valid_in = v;
    tx_eof_in   = e;
    link_up     = lk;
    user_rst    = rst;
    #4;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  // {busy, gbe_rst, state}
  task automatic chk_fsm(input string name, input logic [1:0] s, input logic r);
    chk(name, {28'd0, busy, gbe_rst, status[1:0]}, {28'd0, (s != 2'd0), r, s});
  endtask

  function automatic logic [31:0] st(input int cnt, input logic to, input logic [1:0] s);
    return {16'(cnt), 13'd0, to, s};
  endfunction

  initial begin
    int          pulse;
    logic [1:0]  es;
    logic        v;

    // Table: three 4-word frames with gaps; the gap carries a stray eof with valid low
    for (int f = 0; f < 3; f++) begin
      for (int w = 0; w < 4; w++) begin
        v = 1'b1;
        vecs.push_back('{sw: 32'h0, v: v, e: (w == 3), exp_v: 1'b1,
                         exp_e: (w == 3), exp_status: 32'h0});
      end
      vecs.push_back('{sw: 32'h0, v: 1'b0, e: 1'b1, exp_v: 1'b0,
                       exp_e: 1'b0, exp_status: 32'h0});
    end

    sw_reg = '0; tx_valid_in = 0; tx_eof_in = 0; link_up = 0; user_rst = 1;
    for (int i = 0; i < 3; i++) drive(32'h0, 0, 0, 0, 1);
    drive(32'h0, 0, 0, 0, 0);
    chk("reset_status", status, 32'h0);
    chk_fsm("reset_fsm", 2'd0, 1'b0);

    // 1: IDLE pass-through
    foreach (vecs[k]) begin
      drive(vecs[k].sw, vecs[k].v, vecs[k].e, 0, 0);
      chk("t1_valid", {31'd0, tx_valid_out}, {31'd0, vecs[k].exp_v});
      chk("t1_eof", {31'd0, tx_eof_out}, {31'd0, vecs[k].exp_e});
      chk("t1_status", status, vecs[k].exp_status);
      chk("t1_rst_busy", {30'd0, gbe_rst, busy}, 32'd0);
    end

    // 2: idle-bus request, link_up returns 25 cycles after the edge
    pulse = 0;
    for (int i = 0; i <= 27; i++) begin
      drive(32'h1, 0, 0, (i >= 25), 0);
      es = (i == 0) ? 2'd0 : (i == 1) ? 2'd1 : (i <= 17) ? 2'd2 : (i <= 25) ? 2'd3 : 2'd0;
      chk_fsm("t2_seq", es, (i >= 2 && i <= 17));
      if (gbe_rst) pulse++;
    end
    chk("t2_pulse_len", 32'(pulse), 32'd16);
    chk("t2_status", status, st(1, 0, 2'd0));

    // 3a: 8-word frame, request with word 4; words 4..8 forwarded
    drive(32'h0, 0, 0, 1, 0);
    for (int w = 1; w <= 8; w++) begin
      drive((w >= 4) ? 32'h1 : 32'h0, 1, (w == 8), 1, 0);
      chk("t3_fwd_valid", {31'd0, tx_valid_out}, 32'd1);
      chk("t3_fwd_eof", {31'd0, tx_eof_out}, {31'd0, (w == 8)});
      chk_fsm("t3_state", (w >= 5) ? 2'd1 : 2'd0, 1'b0);
    end
    for (int r = 0; r <= 17; r++) begin
      drive(32'h1, 0, 0, 1, 0);
      es = (r <= 15) ? 2'd2 : (r == 16) ? 2'd3 : 2'd0;
      chk_fsm("t3_after_eof", es, (r <= 15));
    end
    chk("t3_status", status, st(2, 0, 2'd0));

    // 3b: frame starting in DRAIN is suppressed, including its tail during RESET
    drive(32'h0, 0, 0, 1, 0);
    drive(32'h1, 0, 0, 1, 0);
    drive(32'h1, 1, 0, 1, 0);
    chk_fsm("t3b_drain", 2'd1, 1'b0);
    chk("t3b_drop_start", {31'd0, tx_valid_out}, 32'd0);
    for (int r = 0; r <= 17; r++) begin
      drive(32'h1, (r <= 3), (r == 3), 1, 0);
      chk("t3b_drop_tail", {30'd0, tx_valid_out, tx_eof_out}, 32'd0);
      es = (r <= 15) ? 2'd2 : (r == 16) ? 2'd3 : 2'd0;
      chk_fsm("t3b_seq", es, (r <= 15));
    end
    chk("t3b_status", status, st(3, 0, 2'd0));

    // 4: eof never arrives -> drain timeout, then HOLDOFF waits for the late eof
    drive(32'h0, 1, 0, 0, 0);
    chk("t4_first_word", {31'd0, tx_valid_out}, 32'd1);
    drive(32'h1, 0, 0, 0, 0);
    for (int i = 0; i <= 1402; i++) begin
      drive(32'h1, (i == 1400), (i == 1400), 0, 0);
      if (i == 0)    chk_fsm("t4_drain_entry", 2'd1, 1'b0);
      if (i == 1023) chk_fsm("t4_drain_last", 2'd1, 1'b0);
      if (i == 1024) begin
        chk_fsm("t4_rst_rise", 2'd2, 1'b1);
        chk("t4_timeout_flag", status, st(4, 1, 2'd2));
      end
      if (i == 1300) chk_fsm("t4_hold_past_timeout", 2'd3, 1'b0);
      if (i == 1400) chk("t4_late_eof_dropped", {30'd0, tx_valid_out, tx_eof_out}, 32'd0);
      if (i == 1401) chk_fsm("t4_hold_last", 2'd3, 1'b0);
      if (i == 1402) chk("t4_idle_status", status, st(4, 1, 2'd0));
    end

    // 5: hold via bit1 for 100 cycles; bit0 stays high afterwards
    drive(32'h0, 0, 0, 1, 0);
    pulse = 0;
    for (int h = 0; h <= 112; h++) begin
      drive((h < 100) ? 32'h3 : 32'h1, 0, 0, 1, 0);
      es = (h == 0) ? 2'd0 : (h == 1) ? 2'd1 : (h <= 100) ? 2'd2 : (h == 101) ? 2'd3 : 2'd0;
      chk_fsm("t5_seq", es, (h >= 2 && h <= 100));
      if (gbe_rst) pulse++;
    end
    chk("t5_pulse_len", 32'(pulse), 32'd99);
    chk("t5_status", status, st(5, 0, 2'd0));

    // 6: user_rst mid-RESET with bit0 held high
    drive(32'h0, 0, 0, 1, 0);
    for (int g = 0; g <= 6; g++) drive(32'h1, 0, 0, 1, (g == 6));
    chk_fsm("t6_pre_rst", 2'd2, 1'b1);
    for (int g = 7; g <= 26; g++) begin
      drive(32'h1, 0, 0, 1, 0);
      chk("t6_after_rst", {busy, gbe_rst, status[29:0]}, 32'h0);
    end
    drive(32'h0, 0, 0, 1, 0);
    drive(32'h1, 0, 0, 1, 0);
    chk_fsm("t6_edge_idle", 2'd0, 1'b0);
    drive(32'h1, 0, 0, 1, 0);
    chk_fsm("t6_retrigger", 2'd1, 1'b0);
    drive(32'h1, 0, 0, 1, 0);
    chk("t6_count", status, st(1, 0, 2'd2));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
